uop_seq: RTL and testbench

UOP_SEQ -- requirements
Module: uop_seq

---
 rtl/uop_seq.sv | 184 ++++++++++++++++++
 tb/tb_uop_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uop_seq.sv
// Micro-op sequencer: cracks MIPS/Y86 instructions into indexed micro-ops and queues them in a small FIFO.
// Optional same-cycle bypass of an empty FIFO is enabled with `define UOP_SEQ_BYPASS_EN.
module uop_seq #(
   parameter int INST_W   = 48,
   parameter int DEPTH    = 4,
   parameter int MAX_UOPS = 3,
   parameter int IDX_W    = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [INST_W-1:0]          in_inst,
   input  logic                       in_mode,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INST_W-1:0]          out_inst,
   output logic                       out_mode,
   output logic [IDX_W-1:0]           out_idx,
   output logic                       out_last,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       busy
);

   // state | meaning
   // IDLE  | waiting for an instruction; pushes idx 0 on accept
   // CRACK | emitting idx 1..N-1 of the latched instruction
   typedef enum logic [0:0] {IDLE = 1'b0, CRACK = 1'b1} state_t;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    k_q, k_d;
   logic [INST_W-1:0]   lat_inst;
   logic                lat_mode;
   logic [IDX_W-1:0]    lat_last;
   logic                lat_load;

   logic [INST_W-1:0]   mem_inst [DEPTH];
   logic                mem_mode [DEPTH];
   logic [IDX_W-1:0]    mem_idx  [DEPTH];
   logic                mem_last [DEPTH];
   logic [PW-1:0]       rd_ptr, wr_ptr;
   logic [CW-1:0]       count_q;

   logic                full, accept, push, byp, wr_en, rd_en;
   logic [IDX_W-1:0]    in_last_idx;
   logic [INST_W-1:0]   push_inst;
   logic                push_mode;
   logic [IDX_W-1:0]    push_idx;
   logic                push_last;

   assign full     = (count_q == CW'(DEPTH));
   assign in_ready = (state_q == IDLE) && !full && !flush;
   assign accept   = in_valid && in_ready;
   assign busy     = (state_q == CRACK);
   assign count    = count_q;

   // Last micro-op index (N-1) of the offered instruction.
   always_comb begin
      in_last_idx = '0;
      if (in_mode) begin
         if (in_inst[7:4] == 4'hB && in_inst[15:12] != 4'h4)
            in_last_idx = IDX_W'(1);
         else if (in_inst[7:4] == 4'hD)
            in_last_idx = IDX_W'(MAX_UOPS - 1);
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      lat_load  = 1'b0;
      push      = 1'b0;
      push_inst = in_inst;
      push_mode = in_mode;
      push_idx  = '0;
      push_last = (in_last_idx == '0);
      case (state_q)
         IDLE: begin
            if (accept) begin
               push = 1'b1;
               if (in_last_idx != '0) begin
                  state_d  = CRACK;
                  k_d      = IDX_W'(1);
                  lat_load = 1'b1;
               end
            end
         end
         CRACK: begin
            push_inst = lat_inst;
            push_mode = lat_mode;
            push_idx  = k_q;
            push_last = (k_q == lat_last);
            if (!full && !flush) begin
               push = 1'b1;
               if (push_last) begin
                  state_d = IDLE;
                  k_d     = '0;
               end else begin
                  k_d = k_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            k_d     = '0;
         end
      endcase
      if (flush) begin
         state_d = IDLE;
         k_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         k_q      <= '0;
         lat_inst <= '0;
         lat_mode <= 1'b0;
         lat_last <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         if (lat_load) begin
            lat_inst <= in_inst;
            lat_mode <= in_mode;
            lat_last <= in_last_idx;
         end
      end
   end

`ifdef UOP_SEQ_BYPASS_EN
   assign byp = (count_q == '0) && push;
`else
   assign byp = 1'b0;
`endif

   // A bypassed micro-op taken by the consumer never touches the FIFO.
   assign wr_en     = push && !(byp && out_ready);
   assign rd_en     = (count_q != '0) && out_ready && !flush;
   assign out_valid = (count_q != '0) || byp;
   assign out_inst  = byp ? push_inst : mem_inst[rd_ptr];
   assign out_mode  = byp ? push_mode : mem_mode[rd_ptr];
   assign out_idx   = byp ? push_idx  : mem_idx[rd_ptr];
   assign out_last  = byp ? push_last : mem_last[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_inst[i] <= '0;
            mem_mode[i] <= 1'b0;
            mem_idx[i]  <= '0;
            mem_last[i] <= 1'b0;
         end
      end else if (flush) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) begin
            mem_inst[wr_ptr] <= push_inst;
            mem_mode[wr_ptr] <= push_mode;
            mem_idx[wr_ptr]  <= push_idx;
            mem_last[wr_ptr] <= push_last;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (rd_en)
            rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_uop_seq.sv
// Directed bench for uop_seq: cracking, FIFO stall/ordering, flush and bypass latency.
module tb_uop_seq;

   localparam int INST_W = 48;
   localparam int IDX_W  = 2;
`ifdef UOP_SEQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset, flush, in_valid, in_mode, out_ready;
   logic [INST_W-1:0] in_inst;
   logic              in_ready, out_valid, out_mode, out_last, busy;
   logic [INST_W-1:0] out_inst;
   logic [IDX_W-1:0]  out_idx;
   logic [2:0]        count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [18:0] q[$];

   uop_seq dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_mode(out_mode),
      .out_idx(out_idx), .out_last(out_last), .count(count), .busy(busy)
   );

   always #5 clk = ~clk;

   // Record every consumed micro-op as {inst[15:0], idx, last}.
   always @(negedge clk)
      if (!reset && !flush && out_valid && out_ready)
         q.push_back({out_inst[15:0], out_idx, out_last});

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic m, input logic [15:0] ins);
      in_valid = v;
      in_mode  = m;
      in_inst  = {32'h0, ins};
   endtask

   task automatic drain();
      bit done = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(negedge clk);
         if (count == 0 && !busy && !out_valid) done = 1'b1;
         else nxt();
      end
      nxt();
      chk("drain_timeout", 64'(done), 64'd1);
   endtask

   task automatic chk_q(input string tag, input int idx, input logic [18:0] exp);
      logic [18:0] v;
      v = (idx < q.size()) ? q[idx] : 19'h7FFFF;
      chk(tag, 64'(v), 64'(exp));
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 1'b0, 16'h0);
      nxt(); nxt();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_count",     64'(count),     64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
      chk("rst_out_idx",   64'(out_idx),   64'd0);
      chk("rst_out_last",  64'(out_last),  64'd0);
      nxt();

      // MIPS single micro-op
      out_ready = 1'b1;
      in_valid = 1'b1; in_mode = 1'b0; in_inst = 48'h0000_2008_0005;
      @(negedge clk);
      chk("mips_in_ready0", 64'(in_ready), 64'd1);
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      chk("mips_in_ready1", 64'(in_ready), 64'd1);
      chk("mips_count1",    64'(count),    BYP ? 64'd0 : 64'd1);
      nxt();
      drain();
      chk("mips_q_size", 64'(q.size()), 64'd1);
      chk_q("mips_q0", 0, {16'h0005, 2'd0, 1'b1});
      q.delete();

      // POPL rA=0 -> 2 micro-ops
      drive(1'b1, 1'b1, 16'h0FB0);
      @(negedge clk);
      chk("popl_in_ready_a", 64'(in_ready), 64'd1);
      chk("popl_busy_a",     64'(busy),     64'd0);
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      chk("popl_busy_b",     64'(busy),     64'd1);
      chk("popl_in_ready_b", 64'(in_ready), 64'd0);
      nxt();
      @(negedge clk);
      chk("popl_busy_c",     64'(busy),     64'd0);
      chk("popl_in_ready_c", 64'(in_ready), 64'd1);
      nxt();
      drain();
      chk("popl_q_size", 64'(q.size()), 64'd2);
      chk_q("popl_q0", 0, {16'h0FB0, 2'd0, 1'b0});
      chk_q("popl_q1", 1, {16'h0FB0, 2'd1, 1'b1});
      q.delete();

      // POPL rA=4 -> 1 micro-op
      drive(1'b1, 1'b1, 16'h4FB0);
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      chk("popl4_busy", 64'(busy), 64'd0);
      nxt();
      drain();
      chk("popl4_q_size", 64'(q.size()), 64'd1);
      chk_q("popl4_q0", 0, {16'h4FB0, 2'd0, 1'b1});
      q.delete();

      // LEAVE with stalled consumer, then a second instruction
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 16'h00D0);
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      chk("leave_count_b", 64'(count), 64'd1);
      chk("leave_busy_b",  64'(busy),  64'd1);
      nxt();
      @(negedge clk);
      chk("leave_count_c", 64'(count), 64'd2);
      nxt();
      drive(1'b1, 1'b0, 16'h1111);
      @(negedge clk);
      chk("leave_count_d",    64'(count),    64'd3);
      chk("leave_busy_d",     64'(busy),     64'd0);
      chk("leave_in_ready_d", 64'(in_ready), 64'd1);
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      chk("leave_count_e",    64'(count),    64'd4);
      chk("leave_in_ready_e", 64'(in_ready), 64'd0);
      nxt();
      drain();
      chk("leave_q_size", 64'(q.size()), 64'd4);
      chk_q("leave_q0", 0, {16'h00D0, 2'd0, 1'b0});
      chk_q("leave_q1", 1, {16'h00D0, 2'd1, 1'b0});
      chk_q("leave_q2", 2, {16'h00D0, 2'd2, 1'b1});
      chk_q("leave_q3", 3, {16'h1111, 2'd0, 1'b1});
      q.delete();

      // LEAVE into a pre-filled FIFO: stall on full, resume after a pop
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 16'hAAAA);
      nxt();
      drive(1'b1, 1'b0, 16'hBBBB);
      @(negedge clk);
      chk("stall_count_2", 64'(count), 64'd1);
      nxt();
      drive(1'b1, 1'b1, 16'h00D0);
      @(negedge clk);
      chk("stall_count_3",    64'(count),    64'd2);
      chk("stall_in_ready_3", 64'(in_ready), 64'd1);
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      chk("stall_count_4", 64'(count), 64'd3);
      chk("stall_busy_4",  64'(busy),  64'd1);
      nxt();
      @(negedge clk);
      chk("stall_count_5",    64'(count),    64'd4);
      chk("stall_busy_5",     64'(busy),     64'd1);
      chk("stall_in_ready_5", 64'(in_ready), 64'd0);
      nxt();
      @(negedge clk);
      chk("stall_count_6", 64'(count), 64'd4);
      nxt();
      out_ready = 1'b1;
      @(negedge clk);
      chk("stall_count_7", 64'(count),           64'd4);
      chk("stall_head_7",  64'(out_inst[15:0]),  64'hAAAA);
      nxt();
      @(negedge clk);
      chk("stall_count_8", 64'(count), 64'd3);
      chk("stall_busy_8",  64'(busy),  64'd1);
      nxt();
      @(negedge clk);
      chk("stall_count_9", 64'(count), 64'd3);
      chk("stall_busy_9",  64'(busy),  64'd0);
      nxt();
      drain();
      chk("stall_q_size", 64'(q.size()), 64'd5);
      chk_q("stall_q0", 0, {16'hAAAA, 2'd0, 1'b1});
      chk_q("stall_q1", 1, {16'hBBBB, 2'd0, 1'b1});
      chk_q("stall_q2", 2, {16'h00D0, 2'd0, 1'b0});
      chk_q("stall_q3", 3, {16'h00D0, 2'd1, 1'b0});
      chk_q("stall_q4", 4, {16'h00D0, 2'd2, 1'b1});
      q.delete();

      // Flush while cracking LEAVE at k=1
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 16'h77D0);
      nxt();
      in_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      chk("flush_busy_b",     64'(busy),     64'd1);
      chk("flush_in_ready_b", 64'(in_ready), 64'd0);
      nxt();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_count_c",     64'(count),     64'd0);
      chk("flush_busy_c",      64'(busy),      64'd0);
      chk("flush_in_ready_c",  64'(in_ready),  64'd1);
      chk("flush_out_valid_c", 64'(out_valid), 64'd0);
      nxt();
      out_ready = 1'b1;
      repeat (4) nxt();
      @(negedge clk);
      chk("flush_out_valid_late", 64'(out_valid), 64'd0);
      nxt();
      chk("flush_q_size", 64'(q.size()), 64'd0);
      q.delete();

      // Bypass latency
      out_ready = 1'b1;
      drive(1'b1, 1'b0, 16'h3333);
      @(negedge clk);
      chk("byp_out_valid_0", 64'(out_valid), 64'(BYP));
      nxt();
      in_valid = 1'b0;
      @(negedge clk);
      chk("byp_out_valid_1", 64'(out_valid), BYP ? 64'd0 : 64'd1);
      chk("byp_count_1",     64'(count),     BYP ? 64'd0 : 64'd1);
      nxt();
      drain();
      chk("byp_q_size", 64'(q.size()), 64'd1);
      chk_q("byp_q0", 0, {16'h3333, 2'd0, 1'b1});
      q.delete();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
